clause_distributor: RTL and testbench

// Buffered, parametrised clause distributor between the clause source and NUM_QUEUES clause queues.

---
 rtl/clause_distributor.sv | 122 ++++++++++++
 tb/tb_clause_distributor.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clause_distributor.sv
`default_nettype none
// ============================================================================
// Module   : clause_distributor
// Brief    : Buffers incoming clauses in a small FIFO and pushes the head into
//            one non-full clause queue per cycle using round-robin priority.
// Revision : 1.0 - initial release
// ============================================================================
module clause_distributor #(
  parameter int NUM_QUEUES   = 4,
  parameter int CLAUSE_WIDTH = 4,
  parameter int ELEM_CNT     = 1024,
  parameter int ELEM_BITS    = $clog2(ELEM_CNT) + 1,
  parameter int BUF_DEPTH    = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [CLAUSE_WIDTH*ELEM_BITS-1:0] clause_in,
  input  logic                              flush,
  input  logic [NUM_QUEUES-1:0]             full_in,
  output logic [NUM_QUEUES-1:0]             push_out,
  output logic [CLAUSE_WIDTH*ELEM_BITS-1:0] clause_out,
  output logic [$clog2(BUF_DEPTH):0]        occupancy,
  output logic                              idle,
  output logic [CNT_WIDTH-1:0]              push_count,
  output logic [CNT_WIDTH-1:0]              stall_count
);

  localparam int c_cw = CLAUSE_WIDTH * ELEM_BITS;
  localparam int c_aw = $clog2(BUF_DEPTH);
  localparam int c_ow = c_aw + 1;

  logic [c_cw-1:0]         r_mem [BUF_DEPTH];
  logic [c_aw-1:0]         r_wr_ptr;
  logic [c_aw-1:0]         r_rd_ptr;
  logic [c_ow-1:0]         r_count;
  logic [NUM_QUEUES-1:0]   r_base;
  logic [CNT_WIDTH-1:0]    r_push_count;
  logic [CNT_WIDTH-1:0]    r_stall_count;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_accept;
  logic                    w_pop;
  logic                    w_stall;
  logic [NUM_QUEUES-1:0]   w_req;
  logic [2*NUM_QUEUES-1:0] w_dreq;
  logic [2*NUM_QUEUES-1:0] w_dbase;
  logic [2*NUM_QUEUES-1:0] w_dgnt;
  logic [NUM_QUEUES-1:0]   w_grant;

  assign w_full   = (r_count == c_ow'(BUF_DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full && !flush && !reset;
  assign w_accept = in_valid && in_ready;

  assign w_req = (!w_empty && !flush) ? ~full_in : '0;

  // Doubled request vector: subtracting the one-hot base isolates the first
  // request at or above base; the upper half catches the wrap-around case.
  assign w_dreq  = {w_req, w_req};
  assign w_dbase = {{NUM_QUEUES{1'b0}}, r_base};
  assign w_dgnt  = w_dreq & ~(w_dreq - w_dbase);
  assign w_grant = w_dgnt[NUM_QUEUES-1:0] | w_dgnt[2*NUM_QUEUES-1:NUM_QUEUES];

  assign w_pop   = |w_grant;
  assign w_stall = !w_empty && !flush && (&full_in);

  assign push_out    = w_grant;
  assign clause_out  = r_mem[r_rd_ptr];
  assign occupancy   = r_count;
  assign idle        = w_empty;
  assign push_count  = r_push_count;
  assign stall_count = r_stall_count;

  // Storage is not reset; only pointers define validity.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_mem[r_wr_ptr] <= clause_in;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      case ({w_accept, w_pop})
        2'b10:   r_count <= r_count + c_ow'(1);
        2'b01:   r_count <= r_count - c_ow'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_base        <= NUM_QUEUES'(1);
      r_push_count  <= '0;
      r_stall_count <= '0;
    end else begin
      if (w_pop) begin
        r_base       <= {w_grant[NUM_QUEUES-2:0], w_grant[NUM_QUEUES-1]};
        r_push_count <= r_push_count + CNT_WIDTH'(1);
      end
      if (w_stall) begin
        r_stall_count <= r_stall_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_clause_distributor.sv
`default_nettype none
// Testbench for clause_distributor: directed stimulus, queue-based reference
// model checked every cycle, plus hand-computed expectations per scenario.
module tb_clause_distributor;

  localparam int NQ   = 4;
  localparam int CW   = 44;
  localparam int BD   = 4;
  localparam int OW   = 3;
  localparam int CNTW = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [CW-1:0]   clause_in = '0;
  logic            flush = 1'b0;
  logic [NQ-1:0]   full_in = '0;
  logic [NQ-1:0]   push_out;
  logic [CW-1:0]   clause_out;
  logic [OW-1:0]   occupancy;
  logic            idle;
  logic [CNTW-1:0] push_count;
  logic [CNTW-1:0] stall_count;

  clause_distributor dut (
    .clock       (clock),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .clause_in   (clause_in),
    .flush       (flush),
    .full_in     (full_in),
    .push_out    (push_out),
    .clause_out  (clause_out),
    .occupancy   (occupancy),
    .idle        (idle),
    .push_count  (push_count),
    .stall_count (stall_count)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] mk(input int i);
    logic [63:0] v;
    v = 64'h0000_0A50_0000_0000 + 64'(i) * 64'd1237;
    return v[CW-1:0];
  endfunction

  // Reference model: a plain queue of buffered clauses and a base index.
  logic [CW-1:0] mq[$];
  int            m_base  = 0;
  logic [31:0]   m_push  = '0;
  logic [31:0]   m_stall = '0;
  bit            m_valid = 1'b0;
  logic [NQ-1:0] log_push[$];
  logic [CW-1:0] log_clause[$];

  int            gidx;
  bit            exp_rdy;
  logic [NQ-1:0] req;
  logic [NQ-1:0] exp_push;

  always @(negedge clock) begin
    gidx    = -1;
    exp_rdy = (mq.size() < BD) && !flush && !reset;
    if (m_valid) begin
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      if (!reset) begin
        req = (mq.size() > 0 && !flush) ? ~full_in : '0;
        for (int k = 0; k < NQ; k++) begin
          if (gidx < 0 && req[(m_base + k) % NQ]) gidx = (m_base + k) % NQ;
        end
        exp_push = (gidx >= 0) ? (NQ'(1) << gidx) : '0;
        check("push_out", 64'(push_out), 64'(exp_push));
        check("occupancy", 64'(occupancy), 64'(mq.size()));
        check("idle", 64'(idle), 64'(mq.size() == 0));
        check("push_count", 64'(push_count), 64'(m_push));
        check("stall_count", 64'(stall_count), 64'(m_stall));
        if (mq.size() > 0) check("clause_out", 64'(clause_out), 64'(mq[0]));
        if (push_out != '0) begin
          log_push.push_back(push_out);
          log_clause.push_back(clause_out);
        end
      end
    end
    if (reset) begin
      mq.delete();
      m_base  = 0;
      m_push  = '0;
      m_stall = '0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      if (flush) begin
        mq.delete();
      end else begin
        if (mq.size() > 0 && (&full_in)) m_stall++;
        if (gidx >= 0) begin
          void'(mq.pop_front());
          m_base = (gidx + 1) % NQ;
          m_push++;
        end
        if (in_valid && exp_rdy) mq.push_back(clause_in);
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [CW-1:0] c);
    bit rd;
    int t;
    t = 0;
    in_valid  = 1'b1;
    clause_in = c;
    do begin
      @(negedge clock);
      rd = in_ready;
      @(posedge clock);
      #1;
      t++;
    end while (!rd && t < 40);
    if (!rd) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic clear_log();
    log_push.delete();
    log_clause.delete();
  endtask

  logic [NQ-1:0] seq2 [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                              4'b0001, 4'b0010, 4'b0100, 4'b1000};
  logic [NQ-1:0] seq3 [4] = '{4'b0010, 4'b1000, 4'b0010, 4'b1000};
  logic [CNTW-1:0] s0;

  initial begin
    repeat (3) tick();
    reset = 1'b0;

    // Idle after reset
    repeat (10) begin
      @(negedge clock);
      #1;
      check("t1_idle", 64'(idle), 64'd1);
      check("t1_ready", 64'(in_ready), 64'd1);
      check("t1_push", 64'(push_out), 64'd0);
      check("t1_pcnt", 64'(push_count), 64'd0);
      check("t1_scnt", 64'(stall_count), 64'd0);
    end
    tick();

    // Back-to-back stream, all queues free
    clear_log();
    for (int i = 0; i < 8; i++) send(mk(i));
    repeat (3) tick();
    check("t2_npush", 64'(log_push.size()), 64'd8);
    for (int k = 0; k < 8 && k < log_push.size(); k++) begin
      check("t2_grant", 64'(log_push[k]), 64'(seq2[k]));
      check("t2_order", 64'(log_clause[k]), 64'(mk(k)));
    end
    check("t2_pcnt", 64'(push_count), 64'd8);

    // Queues 0 and 2 full
    full_in = 4'b0101;
    clear_log();
    for (int i = 10; i < 14; i++) send(mk(i));
    repeat (4) tick();
    check("t3_npush", 64'(log_push.size()), 64'd4);
    for (int k = 0; k < 4 && k < log_push.size(); k++) begin
      check("t3_grant", 64'(log_push[k]), 64'(seq3[k]));
      check("t3_order", 64'(log_clause[k]), 64'(mk(10 + k)));
    end

    // All queues full: buffer fills, stall counter runs
    full_in = 4'b1111;
    clear_log();
    for (int i = 20; i < 24; i++) send(mk(i));
    in_valid  = 1'b1;
    clause_in = mk(24);
    repeat (3) tick();
    @(negedge clock);
    #1;
    check("t4_ready_low", 64'(in_ready), 64'd0);
    check("t4_occ_full", 64'(occupancy), 64'd4);
    s0 = stall_count;
    repeat (5) tick();
    @(negedge clock);
    #1;
    check("t4_stall_rate", 64'(stall_count), 64'(s0 + 32'd5));
    check("t4_no_push", 64'(log_push.size()), 64'd0);
    tick();
    in_valid = 1'b0;
    full_in  = 4'b1011;
    repeat (6) tick();
    check("t4_npush", 64'(log_push.size()), 64'd4);
    for (int k = 0; k < 4 && k < log_push.size(); k++) begin
      check("t4_grant", 64'(log_push[k]), 64'h4);
      check("t4_order", 64'(log_clause[k]), 64'(mk(20 + k)));
    end

    // Flush with 3 entries buffered; base must survive
    full_in = 4'b1111;
    clear_log();
    for (int i = 30; i < 33; i++) send(mk(i));
    flush   = 1'b1;
    full_in = 4'b0000;
    tick();
    flush = 1'b0;
    @(negedge clock);
    #1;
    check("t5_occ", 64'(occupancy), 64'd0);
    check("t5_idle", 64'(idle), 64'd1);
    check("t5_no_push", 64'(log_push.size()), 64'd0);
    tick();
    send(mk(33));
    repeat (3) tick();
    check("t5_npush", 64'(log_push.size()), 64'd1);
    if (log_push.size() > 0) begin
      check("t5_grant", 64'(log_push[0]), 64'h8);
      check("t5_clause", 64'(log_clause[0]), 64'(mk(33)));
    end

    // Accept and pop in the same cycle at occupancy 2
    full_in = 4'b1111;
    clear_log();
    send(mk(40));
    send(mk(41));
    full_in   = 4'b0000;
    in_valid  = 1'b1;
    clause_in = mk(42);
    tick();
    in_valid = 1'b0;
    full_in  = 4'b1111;
    @(negedge clock);
    #1;
    check("t6_occ", 64'(occupancy), 64'd2);
    check("t6_npush", 64'(log_push.size()), 64'd1);
    if (log_push.size() > 0) check("t6_grant", 64'(log_push[0]), 64'h1);
    tick();
    send(mk(43));
    @(negedge clock);
    #1;
    check("t6_occ3", 64'(occupancy), 64'd3);
    tick();

    // Reset with entries buffered
    clear_log();
    reset   = 1'b1;
    full_in = 4'b0000;
    tick();
    reset = 1'b0;
    repeat (5) begin
      @(negedge clock);
      #1;
      check("t7_occ", 64'(occupancy), 64'd0);
      check("t7_idle", 64'(idle), 64'd1);
      check("t7_push", 64'(push_out), 64'd0);
      check("t7_pcnt", 64'(push_count), 64'd0);
      check("t7_scnt", 64'(stall_count), 64'd0);
    end
    check("t7_no_stale", 64'(log_push.size()), 64'd0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
